// File: rtl/uart_frame_loader.sv
// Framed program loader: length header, payload packed into words and written from BASE_ADDR,
// XOR checksum. Holds the CPU in reset while loading and reports sticky done/err.
module uart_frame_loader #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned BASE_ADDR      = 0,
  parameter bit          BIG_ENDIAN     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_en_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WORD_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] word_count_o
);

  localparam int unsigned BPW = WORD_WIDTH / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BCW-1:0]        BCNT_LAST = BCW'(BPW - 1);
  localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  // IDLE wait load_en | LEN header | DATA payload | CSUM check byte | DONE/ERR wait load_en low
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  hdr_q, hdr_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  hold_q;

  logic [WORD_WIDTH-1:0] byte_ext;
  logic [WORD_WIDTH-1:0] word_nx;
  logic [ADDR_WIDTH-1:0] hdr_len;

  assign byte_ext = WORD_WIDTH'(byte_data_i);
  assign word_nx  = BIG_ENDIAN ? ((shift_q << 8) | byte_ext)
                               : ((shift_q >> 8) | (byte_ext << (WORD_WIDTH - 8)));
  assign hdr_len  = ADDR_WIDTH'({len_hi_q, byte_data_i});

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    csum_d   = csum_q;
    wcnt_d   = wcnt_q;
    tmo_d    = '0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (load_en_i) begin
          state_d = S_LEN;
          hdr_d   = 1'b0;
          bcnt_d  = '0;
          shift_d = '0;
          csum_d  = '0;
          wcnt_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_LEN, S_DATA, S_CSUM: begin
        if (!load_en_i) begin
          state_d = S_IDLE;
        end else if (byte_valid_i) begin
          // a byte always beats a coinciding timeout and restarts the counter
          if (state_q == S_LEN) begin
            if (!hdr_q) begin
              hdr_d    = 1'b1;
              len_hi_d = byte_data_i;
            end else begin
              len_d   = hdr_len;
              state_d = (hdr_len == '0) ? S_CSUM : S_DATA;
            end
          end else if (state_q == S_DATA) begin
            csum_d  = csum_q ^ byte_data_i;
            shift_d = word_nx;
            if (bcnt_q == BCNT_LAST) begin
              bcnt_d = '0;
              we_d   = 1'b1;
              addr_d = BASE + wcnt_q;
              data_d = word_nx;
              wcnt_d = wcnt_q + ADDR_WIDTH'(1);
              if (wcnt_q == len_q - ADDR_WIDTH'(1)) state_d = S_CSUM;
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end else if (byte_data_i == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE, S_ERR: begin
        if (!load_en_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      hdr_q    <= 1'b0;
      len_hi_q <= '0;
      len_q    <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      csum_q   <= '0;
      wcnt_q   <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      csum_q   <= csum_d;
      wcnt_q   <= wcnt_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hold_q   <= load_en_i | (state_q != S_IDLE);
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign mem_we_o     = we_q;
  assign cpu_hold_o   = hold_q;
  assign busy_o       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = wcnt_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: a 16-bit big-endian loader and a 32-bit little-endian loader
// at a wrapping base address, driven by frame tables, corner sequences and random frames.
module tb_uart_frame_loader;

  localparam int T = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        le16, bv16, we16, hold16, busy16, done16, err16;
  logic [7:0]  bd16;
  logic [15:0] a16, d16, wc16;
  logic        le32, bv32, we32, hold32, busy32, done32, err32;
  logic [7:0]  bd32;
  logic [15:0] a32, wc32;
  logic [31:0] d32;

  uart_frame_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(0), .BIG_ENDIAN(1'b1),
                      .TIMEOUT_CYCLES(T)) u16 (
    .clk_i(clk), .rst_i(rst), .load_en_i(le16), .byte_valid_i(bv16), .byte_data_i(bd16),
    .mem_addr_o(a16), .mem_data_o(d16), .mem_we_o(we16), .cpu_hold_o(hold16),
    .busy_o(busy16), .done_o(done16), .err_o(err16), .word_count_o(wc16));

  uart_frame_loader #(.WORD_WIDTH(32), .ADDR_WIDTH(16), .BASE_ADDR(32'hFFFF), .BIG_ENDIAN(1'b0),
                      .TIMEOUT_CYCLES(T)) u32 (
    .clk_i(clk), .rst_i(rst), .load_en_i(le32), .byte_valid_i(bv32), .byte_data_i(bd32),
    .mem_addr_o(a32), .mem_data_o(d32), .mem_we_o(we32), .cpu_hold_o(hold32),
    .busy_o(busy32), .done_o(done32), .err_o(err32), .word_count_o(wc32));

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] wa16_q[$];
  logic [15:0] wd16_q[$];
  logic [15:0] wa32_q[$];
  logic [31:0] wd32_q[$];

  always @(negedge clk) begin
    if (we16) begin wa16_q.push_back(a16); wd16_q.push_back(d16); end
    if (we32) begin wa32_q.push_back(a32); wd32_q.push_back(d32); end
  end

  typedef struct packed {
    logic [3:0]  nb;
    logic [79:0] bytes;
    logic        done;
    logic        err;
    logic [15:0] wc;
    logic [3:0]  nw;
    logic [15:0] wlast;
  } vec_t;

  vec_t vt[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input bit s32, input logic [7:0] b, input int gap);
    repeat (gap) tick();
    if (s32) begin bv32 = 1'b1; bd32 = b; end
    else     begin bv16 = 1'b1; bd16 = b; end
    tick();
    bv16 = 1'b0;
    bv32 = 1'b0;
  endtask

  task automatic clear_q();
    wa16_q.delete(); wd16_q.delete(); wa32_q.delete(); wd32_q.delete();
  endtask

  initial begin
    logic [7:0]  fb[$];
    int          gp[$];
    logic [15:0] ea[$];
    logic [15:0] ed[$];
    logic [7:0]  xs;
    int          nlen, acc, nwords;
    bit          exp_done;

    rst = 1'b1;
    le16 = 1'b0; bv16 = 1'b0; bd16 = '0;
    le32 = 1'b0; bv32 = 1'b0; bd32 = '0;
    #3;
    check("rst_we", we16, 0);
    check("rst_hold", hold16, 0);
    check("rst_busy", busy16, 0);
    check("rst_done_err", {done16, err16}, 0);
    check("rst_wc", wc16, 0);
    tick();
    rst = 1'b0;
    tick();

    // frame table, 16-bit big-endian loader
    vt[0] = '{4'd7, {56'h0002_1234_ABCD_40, 24'h0}, 1'b1, 1'b0, 16'd2, 4'd2, 16'hABCD};
    vt[1] = '{4'd7, {56'h0002_1234_ABCD_98, 24'h0}, 1'b0, 1'b1, 16'd2, 4'd2, 16'hABCD};
    vt[2] = '{4'd3, {24'h000000, 56'h0}, 1'b1, 1'b0, 16'd0, 4'd0, 16'h0};
    vt[3] = '{4'd3, {24'h000001, 56'h0}, 1'b0, 1'b1, 16'd0, 4'd0, 16'h0};
    vt[4] = '{4'd5, {40'h0001_FF00_FF, 40'h0}, 1'b1, 1'b0, 16'd1, 4'd1, 16'hFF00};
    vt[5] = '{4'd9, {72'h0003_0102_0304_0506_07, 8'h0}, 1'b1, 1'b0, 16'd3, 4'd3, 16'h0506};
    vt[6] = '{4'd9, {72'h0003_0102_0304_0506_00, 8'h0}, 1'b0, 1'b1, 16'd3, 4'd3, 16'h0506};

    for (int i = 0; i < 7; i++) begin
      clear_q();
      le16 = 1'b1;
      tick();
      check($sformatf("v%0d_len_busy", i), busy16, 1);
      check($sformatf("v%0d_len_clear", i), {done16, err16, wc16}, 0);
      for (int k = 0; k < int'(vt[i].nb); k++) send(1'b0, vt[i].bytes[79 - 8*k -: 8], 0);
      tick();
      check($sformatf("v%0d_done", i), done16, vt[i].done);
      check($sformatf("v%0d_err", i), err16, vt[i].err);
      check($sformatf("v%0d_wc", i), wc16, vt[i].wc);
      check($sformatf("v%0d_nwrites", i), wa16_q.size(), vt[i].nw);
      check($sformatf("v%0d_busy_end", i), busy16, 0);
      check($sformatf("v%0d_hold", i), hold16, 1);
      for (int j = 0; j < wa16_q.size(); j++) check($sformatf("v%0d_addr%0d", i, j), wa16_q[j], j);
      if (vt[i].nw != 0) check($sformatf("v%0d_wlast", i), wd16_q[wd16_q.size()-1], vt[i].wlast);
      le16 = 1'b0;
      tick();
      check($sformatf("v%0d_hold_lag", i), hold16, 1);
      tick();
      check($sformatf("v%0d_hold_off", i), hold16, 0);
      check($sformatf("v%0d_sticky", i), {done16, err16}, {vt[i].done, vt[i].err});
    end

    // timeout inside a partial word
    clear_q();
    le16 = 1'b1; tick();
    send(0, 8'h00, 0); send(0, 8'h02, 0); send(0, 8'h12, 0); send(0, 8'h34, 0); send(0, 8'hAB, 0);
    repeat (T-1) tick();
    check("tmo_before", {err16, busy16}, 2'b01);
    tick();
    check("tmo_err", {err16, done16, busy16}, 3'b100);
    check("tmo_nwrites", wa16_q.size(), 1);
    check("tmo_word0", wd16_q[0], 16'h1234);
    le16 = 1'b0; tick(); tick();

    // gaps of T-1 idle cycles are tolerated
    clear_q();
    le16 = 1'b1; tick();
    send(0, 8'h00, T-1); send(0, 8'h01, T-1); send(0, 8'hAA, T-1); send(0, 8'hBB, T-1);
    send(0, 8'h11, T-1);
    tick();
    check("gap_ok", {done16, err16}, 2'b10);
    check("gap_word", wd16_q[0], 16'hAABB);
    le16 = 1'b0; tick(); tick();

    // write latency, single-cycle strobe, abort mid-word, bytes ignored in IDLE
    clear_q();
    le16 = 1'b1; tick();
    send(0, 8'h00, 0); send(0, 8'h02, 0); send(0, 8'h12, 0); send(0, 8'h34, 0);
    check("lat_we", we16, 1);
    check("lat_addr_data", {a16, d16}, {16'h0000, 16'h1234});
    check("lat_wc", wc16, 1);
    tick();
    check("lat_we_1cyc", we16, 0);
    send(0, 8'hAB, 0);
    le16 = 1'b0;
    tick();
    check("abort_idle", {busy16, err16, done16}, 3'b000);
    check("abort_hold_lag", hold16, 1);
    tick();
    check("abort_hold_off", hold16, 0);
    send(0, 8'hCD, 0); send(0, 8'hEF, 0); tick();
    check("idle_ignore", {busy16, 16'(wa16_q.size()), wc16}, {1'b0, 16'd1, 16'd1});

    // asynchronous reset with a write strobe pending
    clear_q();
    le16 = 1'b1; tick();
    send(0, 8'h00, 0); send(0, 8'h02, 0); send(0, 8'h12, 0); send(0, 8'h34, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_we", we16, 0);
    check("arst_outs", {hold16, busy16, done16, err16, wc16, a16, d16}, 0);
    le16 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("arst_nwrites", wa16_q.size(), 0);

    // 32-bit little-endian loader at base 0xFFFF
    clear_q();
    le32 = 1'b1; tick();
    send(1, 8'h00, 0); send(1, 8'h01, 0);
    send(1, 8'h11, 0); send(1, 8'h22, 0); send(1, 8'h33, 0); send(1, 8'h44, 0);
    check("w32_we", we32, 1);
    check("w32_addr_data", {a32, d32}, {16'hFFFF, 32'h44332211});
    send(1, 8'h44, 0); tick();
    check("w32_done", {done32, err32, wc32}, {2'b10, 16'd1});
    le32 = 1'b0; tick(); tick();
    clear_q();
    le32 = 1'b1; tick();
    send(1, 8'h00, 0); send(1, 8'h02, 0);
    for (int k = 1; k <= 8; k++) send(1, 8'(k), 0);
    send(1, 8'h08, 0); tick();
    check("wrap_done", {done32, err32, wc32}, {2'b10, 16'd2});
    check("wrap_n", wa32_q.size(), 2);
    check("wrap_w0", {wa32_q[0], wd32_q[0]}, {16'hFFFF, 32'h04030201});
    check("wrap_w1", {wa32_q[1], wd32_q[1]}, {16'h0000, 32'h08070605});
    le32 = 1'b0; tick(); tick();

    // random frames against a frame-level reference model
    for (int f = 0; f < 30; f++) begin
      int r;
      fb.delete(); gp.delete(); ea.delete(); ed.delete();
      nlen = $urandom_range(0, 4);
      fb.push_back(8'(nlen >> 8));
      fb.push_back(8'(nlen));
      xs = '0;
      for (int k = 0; k < 2*nlen; k++) begin
        fb.push_back(8'($urandom_range(0, 255)));
        xs ^= fb[fb.size()-1];
      end
      if ($urandom_range(0, 3) == 0) fb.push_back(xs ^ 8'($urandom_range(1, 255)));
      else                           fb.push_back(xs);
      for (int k = 0; k < fb.size(); k++) begin
        r = $urandom_range(0, 59);
        gp.push_back(r < 55 ? r % 3 : (r < 58 ? T-1 : T));
      end
      acc = fb.size();
      for (int k = fb.size() - 1; k >= 0; k--) if (gp[k] >= T) acc = k;
      nwords = (acc > 2) ? (acc - 2) / 2 : 0;
      if (nwords > nlen) nwords = nlen;
      for (int w = 0; w < nwords; w++) begin
        ea.push_back(16'(w));
        ed.push_back({fb[2 + 2*w], fb[3 + 2*w]});
      end
      exp_done = (acc == fb.size()) && (fb[fb.size()-1] == xs);

      clear_q();
      le16 = 1'b1; tick();
      for (int k = 0; k < fb.size(); k++) send(0, fb[k], gp[k]);
      repeat (T + 2) tick();
      check($sformatf("r%0d_done_err", f), {done16, err16}, {exp_done, !exp_done});
      check($sformatf("r%0d_wc", f), wc16, nwords);
      check($sformatf("r%0d_nwrites", f), wa16_q.size(), nwords);
      for (int w = 0; w < nwords && w < wa16_q.size(); w++)
        check($sformatf("r%0d_w%0d", f, w), {wa16_q[w], wd16_q[w]}, {ea[w], ed[w]});
      le16 = 1'b0; tick(); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
